// File: rtl/axil_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// axil_read_arbiter_if
// AXI-lite read-channel bundle (AR + R) used on both sides of the read
// arbiter.
//   araddr  : read address            (master -> slave)
//   arvalid : address valid           (master -> slave)
//   arready : address accepted        (slave  -> master)
//   rdata   : read data               (slave  -> master)
//   rvalid  : read data valid         (slave  -> master)
//   rready  : read data accepted      (master -> slave)
// ---------------------------------------------------------------------------
interface axil_read_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rvalid
  );

endinterface

// File: rtl/axil_read_arbiter.sv
// ---------------------------------------------------------------------------
// axil_read_arbiter
// Shares the single AXI-lite read channel of main RAM between instruction
// fetch (port 0) and data load (port 1). One transaction is outstanding at a
// time: the winner's address is captured, replayed to RAM, and the RAM
// response is passed straight back to the granted port.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   s0    : requester port 0 (fetch), slave side of the arbiter
//   s1    : requester port 1 (load), slave side of the arbiter
//   m     : master side towards the main RAM read slave
//   grant : index of the current or last granted port
//   busy  : a transaction is in flight (ADDR or DATA)
// ---------------------------------------------------------------------------
module axil_read_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst,
  axil_read_arbiter_if.slave  s0,
  axil_read_arbiter_if.slave  s1,
  axil_read_arbiter_if.master m,
  output logic                grant,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  grant_r;
  logic                  last_grant_r;
  logic                  req_s;
  logic                  winner_s;
  logic                  ar_hs_s;
  logic                  sel_rready_s;
  logic                  r_hs_s;

  // Arbitration: pick the port that gets the AR slot while idle.
  always_comb begin
    req_s    = s0.arvalid | s1.arvalid;
    winner_s = 1'b0;
    if (s0.arvalid && s1.arvalid) begin
      if (FIXED_PRIO != 0) begin
        winner_s = 1'b0;
      end else begin
        winner_s = ~last_grant_r;
      end
    end else if (s1.arvalid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Handshake qualifiers. rst gates the AR accept so nothing is acknowledged
  // while reset is held.
  always_comb begin
    ar_hs_s      = (state_r == IDLE) && req_s && rst;
    sel_rready_s = grant_r ? s1.rready : s0.rready;
    r_hs_s       = (state_r == DATA) && m.rvalid && sel_rready_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ar_hs_s) begin
          state_s = ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (m.arready) begin
          state_s = DATA;
        end else begin
          state_s = ADDR;
        end
      end
      DATA: begin
        if (r_hs_s) begin
          state_s = IDLE;
        end else begin
          state_s = DATA;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Channel outputs: AR accept in IDLE, RAM request in ADDR, R routing in DATA.
  always_comb begin
    s0.arready = 1'b0;
    s1.arready = 1'b0;
    s0.rvalid  = 1'b0;
    s1.rvalid  = 1'b0;
    s0.rdata   = {DATA_WIDTH{1'b0}};
    s1.rdata   = {DATA_WIDTH{1'b0}};
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;
    m.araddr   = addr_r;
    case (state_r)
      IDLE: begin
        if (rst) begin
          s0.arready = req_s & ~winner_s;
          s1.arready = req_s & winner_s;
        end else begin
          s0.arready = 1'b0;
          s1.arready = 1'b0;
        end
      end
      ADDR: begin
        m.arvalid = 1'b1;
      end
      DATA: begin
        m.rready = sel_rready_s;
        if (grant_r) begin
          s1.rvalid = m.rvalid;
          s1.rdata  = m.rdata;
        end else begin
          s0.rvalid = m.rvalid;
          s0.rdata  = m.rdata;
        end
      end
      default: m.arvalid = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Captured address and grant history; last_grant starts at 1 so port 0
  // wins the first contended round.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r       <= {ADDR_WIDTH{1'b0}};
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      if (ar_hs_s) begin
        addr_r  <= winner_s ? s1.araddr : s0.araddr;
        grant_r <= winner_s;
      end
      if (r_hs_s) begin
        last_grant_r <= grant_r;
      end
    end
  end

  assign grant = grant_r;
  assign busy  = (state_r != IDLE);

endmodule

// File: tb/tb_axil_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axil_read_arbiter
// Directed bench for axil_read_arbiter. The main instance (round-robin) has
// its RAM side driven step by step; a second instance with FIXED_PRIO=1 sits
// behind a zero-wait RAM model and is used for the fixed-priority ordering.
// ---------------------------------------------------------------------------
module tb_axil_read_arbiter;

  logic clk;
  logic rst;
  logic grant;
  logic busy;
  logic grant2;
  logic busy2;

  int checks;
  int errors;

  axil_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s0_if ();
  axil_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s1_if ();
  axil_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();
  axil_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) p0_if ();
  axil_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) p1_if ();
  axil_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) pm_if ();

  axil_read_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIXED_PRIO(0)) dut (
    .clk   (clk),
    .rst   (rst),
    .s0    (s0_if),
    .s1    (s1_if),
    .m     (m_if),
    .grant (grant),
    .busy  (busy)
  );

  axil_read_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIXED_PRIO(1)) dut_fp (
    .clk   (clk),
    .rst   (rst),
    .s0    (p0_if),
    .s1    (p1_if),
    .m     (pm_if),
    .grant (grant2),
    .busy  (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait RAM for the fixed-priority instance.
  assign pm_if.arready = 1'b1;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_if.rvalid <= 1'b0;
      pm_if.rdata  <= 32'h0;
    end else if (pm_if.arvalid && pm_if.arready) begin
      pm_if.rvalid <= 1'b1;
      pm_if.rdata  <= pm_if.araddr + 32'h1;
    end else if (pm_if.rvalid && pm_if.rready) begin
      pm_if.rvalid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One zero-wait transaction; the caller already holds the request of port p.
  task automatic txn(input logic p, input logic [31:0] a, input logic [31:0] d);
    #1;
    chk("ar_ready_win", p ? s1_if.arready : s0_if.arready, 32'd1);
    chk("ar_ready_lose", p ? s0_if.arready : s1_if.arready, 32'd0);
    tick;
    #1;
    chk("grant", {31'd0, grant}, {31'd0, p});
    chk("m_arvalid", {31'd0, m_if.arvalid}, 32'd1);
    chk("m_araddr", m_if.araddr, a);
    chk("busy_addr", {31'd0, busy}, 32'd1);
    m_if.arready = 1'b1;
    tick;
    m_if.arready = 1'b0;
    m_if.rvalid  = 1'b1;
    m_if.rdata   = d;
    #1;
    chk("rvalid_own", p ? s1_if.rvalid : s0_if.rvalid, 32'd1);
    chk("rdata_own", p ? s1_if.rdata : s0_if.rdata, d);
    chk("rvalid_other", p ? s0_if.rvalid : s1_if.rvalid, 32'd0);
    chk("rdata_other", p ? s0_if.rdata : s1_if.rdata, 32'd0);
    chk("m_rready", {31'd0, m_if.rready}, 32'd1);
    tick;
    m_if.rvalid = 1'b0;
    m_if.rdata  = 32'h0;
  endtask

  int order[$];
  int n_ar0;
  int n_ar1;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    s0_if.araddr = 32'h10; s0_if.arvalid = 1'b1; s0_if.rready = 1'b1;
    s1_if.araddr = 32'h0;  s1_if.arvalid = 1'b0; s1_if.rready = 1'b1;
    m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = 32'h0;
    p0_if.araddr = 32'h100; p0_if.arvalid = 1'b0; p0_if.rready = 1'b1;
    p1_if.araddr = 32'h200; p1_if.arvalid = 1'b0; p1_if.rready = 1'b1;

    // Reset values, with a request pending that must not be acknowledged.
    #3;
    chk("rst_s0_arready", {31'd0, s0_if.arready}, 32'd0);
    chk("rst_m_arvalid", {31'd0, m_if.arvalid}, 32'd0);
    chk("rst_m_rready", {31'd0, m_if.rready}, 32'd0);
    chk("rst_m_araddr", m_if.araddr, 32'h0);
    chk("rst_grant", {31'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_s0_rdata", s0_if.rdata, 32'h0);
    s0_if.arvalid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;

    // Single fetch from port 0.
    s0_if.araddr = 32'h10; s0_if.arvalid = 1'b1;
    txn(1'b0, 32'h10, 32'hDEADBEEF);
    s0_if.arvalid = 1'b0;
    #1;
    chk("idle_after_fetch", {31'd0, busy}, 32'd0);
    tick;

    // Simultaneous requests right after reset: port 0 first, then port 1.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick;
    s0_if.araddr = 32'h4; s0_if.arvalid = 1'b1;
    s1_if.araddr = 32'h8; s1_if.arvalid = 1'b1;
    txn(1'b0, 32'h4, 32'hA0A0A0A0);
    txn(1'b1, 32'h8, 32'hB1B1B1B1);

    // Continuous contention: round-robin alternates 0,1,0,1,...
    s0_if.araddr = 32'h100;
    s1_if.araddr = 32'h200;
    for (int i = 0; i < 8; i++) begin
      txn(i[0], i[0] ? 32'h200 : 32'h100, 32'hC000_0000 + i);
    end
    s0_if.arvalid = 1'b0;
    s1_if.arvalid = 1'b0;
    tick;

    // Backpressure on AR from RAM and on R from port 0.
    s0_if.araddr = 32'h20; s0_if.arvalid = 1'b1;
    tick;
    s0_if.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_m_arvalid", {31'd0, m_if.arvalid}, 32'd1);
      chk("bp_m_araddr", m_if.araddr, 32'h20);
      tick;
    end
    m_if.arready = 1'b1;
    tick;
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'h55; s0_if.rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_m_rready", {31'd0, m_if.rready}, 32'd0);
      chk("bp_s0_rvalid", {31'd0, s0_if.rvalid}, 32'd1);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      tick;
    end
    s0_if.rready = 1'b1;
    #1;
    chk("bp_m_rready_up", {31'd0, m_if.rready}, 32'd1);
    tick;
    m_if.rvalid = 1'b0;
    #1;
    chk("bp_done", {31'd0, busy}, 32'd0);
    tick;

    // Port 1 requests while port 0 is being served.
    s0_if.araddr = 32'h30; s0_if.arvalid = 1'b1;
    tick;
    s0_if.arvalid = 1'b0;
    s1_if.araddr = 32'h40; s1_if.arvalid = 1'b1;
    m_if.arready = 1'b1;
    #1;
    chk("busy_s1_arready_addr", {31'd0, s1_if.arready}, 32'd0);
    tick;
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'h33; s0_if.rready = 1'b0;
    #1;
    chk("busy_s1_arready_data", {31'd0, s1_if.arready}, 32'd0);
    tick;
    s0_if.rready = 1'b1;
    tick;
    m_if.rvalid = 1'b0;
    txn(1'b1, 32'h40, 32'h44);
    s1_if.arvalid = 1'b0;
    tick;

    // Reset while in ADDR, then a fresh port 1 request.
    s0_if.araddr = 32'h50; s0_if.arvalid = 1'b1;
    tick;
    s0_if.arvalid = 1'b0;
    #1;
    chk("pre_rst_m_arvalid", {31'd0, m_if.arvalid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_m_arvalid", {31'd0, m_if.arvalid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_m_araddr", m_if.araddr, 32'h0);
    rst = 1'b1;
    tick;
    s1_if.araddr = 32'h60; s1_if.arvalid = 1'b1;
    txn(1'b1, 32'h60, 32'h66);
    s1_if.arvalid = 1'b0;
    tick;

    // Fixed priority: port 0 drains all four requests before port 1.
    p0_if.arvalid = 1'b1;
    p1_if.arvalid = 1'b1;
    n_ar0 = 0;
    n_ar1 = 0;
    for (int c = 0; c < 200 && order.size() < 8; c++) begin
      #1;
      if (p0_if.arvalid && p0_if.arready) n_ar0++;
      if (p1_if.arvalid && p1_if.arready) n_ar1++;
      if (p0_if.rvalid && p0_if.rready) order.push_back(0);
      if (p1_if.rvalid && p1_if.rready) order.push_back(1);
      tick;
      if (n_ar0 == 4) p0_if.arvalid = 1'b0;
      if (n_ar1 == 4) p1_if.arvalid = 1'b0;
    end
    chk("fp_count", order.size(), 32'd8);
    for (int i = 0; i < order.size(); i++) begin
      chk("fp_order", order[i], (i < 4) ? 32'd0 : 32'd1);
    end
    p0_if.arvalid = 1'b0;
    p1_if.arvalid = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_read_arbiter.md
Name: axil_read_arbiter

Overview:
Shares the single AXI-lite read channel of main RAM between two requesters: port 0 (instruction fetch) and port 1 (data load). It sits between the core's fetch/LSU read masters and the main RAM read slave. It grants one requester at a time, forwards the captured address, and routes the read data back to the granted port. Only one transaction is outstanding at a time.

Parameters:
- DATA_WIDTH, core_pkg DATA_WIDTH (32): read data width.
- ADDR_WIDTH, 32: address width.
- FIXED_PRIO, 0: 0 = round-robin arbitration; 1 = port 0 always wins.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- S0_ARADDR  in  ADDR_WIDTH  port 0 read address.
- S0_ARVALID  in  1  port 0 address valid.
- S0_ARREADY  out  1  port 0 address accepted.
- S0_RDATA  out  DATA_WIDTH  port 0 read data.
- S0_RVALID  out  1  port 0 data valid.
- S0_RREADY  in  1  port 0 data ready.
- S1_ARADDR, S1_ARVALID, S1_ARREADY, S1_RDATA, S1_RVALID, S1_RREADY: same as port 0, for port 1.
- M_ARADDR  out  ADDR_WIDTH  address to RAM.
- M_ARVALID  out  1  address valid to RAM.
- M_ARREADY  in  1  RAM address ready.
- M_RDATA  in  DATA_WIDTH  RAM read data.
- M_RVALID  in  1  RAM data valid.
- M_RREADY  out  1  ready to RAM.
- GRANT  out  1  index of the current or last granted port.
- BUSY  out  1  high in ADDR and DATA states.

Behaviour:
- Reset: clk/rst are one clock with asynchronous active-low reset. While rst=0 (asynchronous):
  - state is IDLE, addr_q=0, GRANT=0, last_grant=1 (so port 0 wins first).
  - All ARREADY, RVALID, M_ARVALID and M_RREADY are 0; all RDATA are 0; M_ARADDR=0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Winner is computed combinationally:
    - Only one ARVALID is high: that port wins.
    - Both are high: the winner is !last_grant when FIXED_PRIO=0, otherwise port 0.
  - The winner's S*_ARREADY=1 (combinational); the other port's ARREADY=0.
  - On the handshake, the next edge loads addr_q from the winner's ARADDR, sets GRANT=winner, and moves to ADDR.
  - No ARVALID: stay in IDLE.
- ADDR:
  - M_ARVALID=1 and M_ARADDR=addr_q, held stable until M_ARREADY.
  - On M_ARVALID&M_ARREADY, go to DATA.
  - Both S*_ARREADY are 0.
- DATA:
  - S[GRANT]_RVALID=M_RVALID, S[GRANT]_RDATA=M_RDATA, M_RREADY=S[GRANT]_RREADY.
  - The non-granted port sees RVALID=0 and RDATA=0.
  - On M_RVALID&M_RREADY: last_grant<=GRANT, go to IDLE.
- Outside DATA: M_RREADY=0, and both S*_RVALID/RDATA are 0.
- Latency:
  - M_ARVALID rises 1 cycle after the S-side AR handshake.
  - The R path is combinational pass-through (0 cycles).
  - A new grant is possible in the cycle after the R handshake.
  - Minimum 3 cycles per transaction with a zero-wait RAM.
- Requests arriving while BUSY are not acknowledged. The requester must hold ARVALID/ARADDR until ARREADY; the arbiter never drops a pending request.
- Round-robin fairness: under continuous requests from both ports, grants alternate 0,1,0,1.
- A requester deasserting ARVALID before its handshake forfeits the slot; no state change.
- M_RVALID is ignored in IDLE/ADDR: M_RREADY=0 and no routing.
- Reset mid-transaction: an immediate return to IDLE; M_ARVALID and M_RREADY drop asynchronously; no response is delivered to either port.
- Address and data are passed unmodified; no width conversion.

Test Plan:
- Single fetch: S0_ARADDR=0x10, S0_ARVALID=1, RAM returns 0xDEADBEEF -> S0_ARREADY=1 in cycle 0; M_ARADDR=0x10, M_ARVALID=1 from cycle 1; S0_RDATA=0xDEADBEEF with S0_RVALID=1; S1_RVALID stays 0.
- Simultaneous requests after reset: S0 addr 0x4, S1 addr 0x8, both held -> port 0 is served first, then port 1; GRANT sequence 0,1; each port receives only its own data.
- Continuous contention, 4 transactions per port -> grants alternate 0,1,0,1,0,1,0,1; with FIXED_PRIO=1, all of port 0's transactions complete before port 1 is granted.
- Backpressure:
  - M_ARREADY held 0 for 5 cycles -> M_ARVALID and M_ARADDR are stable throughout.
  - S0_RREADY held 0 for 3 cycles -> M_RREADY=0; the handshake completes when S0_RREADY rises.
- Request while busy: S1 asserts ARVALID during port 0's DATA state -> S1_ARREADY=0 until IDLE, then S1 is granted on the next cycle.
- Reset asserted in ADDR state -> M_ARVALID=0 immediately; after release the state is IDLE and a new S1 request is served normally.
